led_frame_arbiter: RTL and testbench
====================================

// Module: led_frame_arbiter
// PURPOSE
//   Shares the single WS2811 LED-array driver between NUM_SRC frame producers (game LED
//   generator, score animation, idle animation). One requester is granted the strip at a time.
//   It writes pixels into a shadow frame and commits it. The block copies shadow to the
//   active frame only while the driver is idle, then pulses drv_start. Sits between the
//   game-component LED sources and WS2811_array_controller (external-RGB mode).
// PARAMETERS
//   NUM_SRC     3    number of requesters; index 0 = highest priority
//   LED_COUNT   11   pixels per frame
//   COLOR_W     24   bits per pixel (GRB as consumed by driver)
//   HOLD_FRAMES 4    frames a granted source keeps the strip before higher-priority preemption
// PORTS
//   clock         in   1                  system clock
//   reset         in   1                  synchronous, active-high
//   src_req       in   NUM_SRC            level: source wants the strip
//   src_wr_valid  in   NUM_SRC            pixel write strobe per source
//   src_wr_idx    in   NUM_SRC*4          pixel index per source (slice s = [4s+3:4s])
//   src_wr_color  in   NUM_SRC*COLOR_W    pixel colour per source
//   src_commit    in   NUM_SRC            1-cycle pulse: shadow frame complete
//   src_grant     out  NUM_SRC            one-hot (or zero) current owner
//   drv_busy      in   1                  driver transmitting/latching
//   drv_start     out  1                  1-cycle pulse: new frame_out valid, start send
//   frame_out     out  LED_COUNT*COLOR_W  active frame; led k = [COLOR_W*k +: COLOR_W]
//   frame_count   out  16                 frames delivered since reset, wraps at 16'hFFFF->0
// BEHAVIOUR
//   Reset: state IDLE; src_grant=0, drv_start=0, frame_out=0, shadow=0, frame_count=0, hold=0.
//   FSM IDLE -> FILL -> WAIT_DRV -> SEND -> ARB:
//   - IDLE: any src_req -> grant lowest set index, hold=0, -> FILL (grant visible next cycle).
//   - FILL: only the granted source's writes land in shadow; other sources' writes are dropped.
//     wr_idx >= LED_COUNT is ignored. Write and commit in the same cycle: write applies first.
//     Granted commit -> WAIT_DRV. Granted src_req low -> grant=0, -> IDLE; shadow kept, frame_out
//     untouched.
//   - WAIT_DRV: when drv_busy=0, frame_out<=shadow, drv_start=1 for exactly one cycle,
//     frame_count++, hold++ (saturating at HOLD_FRAMES) -> SEND. With drv_busy=0 at commit,
//     drv_start is asserted 2 cycles after the commit cycle.
//   - SEND: wait for drv_busy rising, then falling -> ARB. No rise within 256 cycles: treat as
//     done (driver already idle).
//   - ARB (1 cycle): owner req low -> IDLE (or regrant if another req is set, hold=0).
//     A higher-priority req with hold>=HOLD_FRAMES -> switch grant, hold=0, -> FILL.
//     Otherwise keep owner -> FILL. Lower-priority requests never preempt.
//   - frame_out changes only in WAIT_DRV->SEND transitions; it never changes while drv_busy=1.
//   - Reset mid-operation: all state returns to reset values next cycle, including
//     frame_out=0 (strip goes dark on next driver refresh).
//   - At most one bit of src_grant is set. drv_start is never asserted on consecutive cycles.
// STRUCTURE
//   Shared package/include led_frame_pkg: LED_COUNT, COLOR_W, IDX_W=4, FSM state encoding,
//   SEND_TIMEOUT=256.
//   Sub-module led_prio_arbiter (fixed-priority, lowest index wins, one-hot out); everything
//   else is in this module: FSM, shadow/active arrays, hold counter, timeout counter.
// TESTING
//   1. Src1 only: req, writes idx0..10 = 24'h0000FF+k, commit, drv_busy=0
//      -> drv_start 2 cycles after commit, frame_out matches, frame_count=1.
//   2. Src2 writes while src1 granted -> frame_out has no src2 data. Write idx 11/15 ignored.
//   3. Commit while drv_busy=1 for 50 cycles -> frame_out stable throughout.
//      drv_start is asserted in the cycle after drv_busy falls.
//   4. Src2 owner, src0 requests at frame 1 -> src2 keeps the strip through frame 4.
//      Grant moves to src0 on ARB after frame 4 (HOLD_FRAMES=4).
//   5. Owner drops req in FILL -> grant=0 next cycle, no drv_start, old frame_out retained.
//   6. Reset asserted in WAIT_DRV -> next cycle all outputs zero, state IDLE.
//      Driver never raises busy in SEND -> ARB after 256 cycles.

Source files
------------

// File: rtl/led_frame_pkg.sv
// Shared constants and FSM encoding for the LED frame arbiter.
package led_frame_pkg;

    localparam int unsigned LED_COUNT    = 11;
    localparam int unsigned COLOR_W      = 24;
    localparam int unsigned IDX_W        = 4;
    localparam int unsigned SEND_TIMEOUT = 256;
    localparam int unsigned TMO_W        = $clog2(SEND_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StFill,
        StWaitDrv,
        StSend,
        StArb
    } state_t;

endpackage

// File: rtl/led_prio_arbiter.sv
// Fixed-priority arbiter: the lowest set request index wins, one-hot grant.
module led_prio_arbiter #(
    parameter int unsigned N = 3
) (
    input  logic [N-1:0] req,
    output logic [N-1:0] grant
);

    logic found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_frame_arbiter.sv
// Shares one WS2811 driver between several frame producers: the granted source fills a
// shadow frame, which is copied to the active frame only while the driver is idle.
module led_frame_arbiter #(
    parameter int unsigned NUM_SRC     = 3,
    parameter int unsigned LED_COUNT   = led_frame_pkg::LED_COUNT,
    parameter int unsigned COLOR_W     = led_frame_pkg::COLOR_W,
    parameter int unsigned HOLD_FRAMES = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           src_req,
    input  logic [NUM_SRC-1:0]           src_wr_valid,
    input  logic [NUM_SRC*4-1:0]         src_wr_idx,
    input  logic [NUM_SRC*COLOR_W-1:0]   src_wr_color,
    input  logic [NUM_SRC-1:0]           src_commit,
    output logic [NUM_SRC-1:0]           src_grant,
    input  logic                         drv_busy,
    output logic                         drv_start,
    output logic [LED_COUNT*COLOR_W-1:0] frame_out,
    output logic [15:0]                  frame_count
);

    import led_frame_pkg::*;

    localparam int unsigned HOLD_W = $clog2(HOLD_FRAMES + 1);

    state_t                         state;
    logic [HOLD_W-1:0]              hold;
    logic [TMO_W-1:0]               tmo_cnt;
    logic                           seen_busy;
    logic [LED_COUNT*COLOR_W-1:0]   shadow;
    logic [NUM_SRC-1:0]             pick;

    logic                           own_req;
    logic                           own_valid;
    logic                           own_commit;
    logic [IDX_W-1:0]               own_idx;
    logic [COLOR_W-1:0]             own_color;

    led_prio_arbiter #(
        .N(NUM_SRC)
    ) u_prio (
        .req  (src_req),
        .grant(pick)
    );

    // Select the current owner's request and write port; all zero when nothing is granted.
    always_comb begin
        own_req    = 1'b0;
        own_valid  = 1'b0;
        own_commit = 1'b0;
        own_idx    = '0;
        own_color  = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (src_grant[s]) begin
                own_req    = src_req[s];
                own_valid  = src_wr_valid[s];
                own_commit = src_commit[s];
                own_idx    = src_wr_idx[s*IDX_W +: IDX_W];
                own_color  = src_wr_color[s*COLOR_W +: COLOR_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= StIdle;
            src_grant   <= '0;
            hold        <= '0;
            tmo_cnt     <= '0;
            seen_busy   <= 1'b0;
            shadow      <= '0;
            frame_out   <= '0;
            drv_start   <= 1'b0;
            frame_count <= '0;
        end else begin
            drv_start <= 1'b0;
            unique case (state)
                StIdle: begin
                    if (|src_req) begin
                        src_grant <= pick;
                        hold      <= '0;
                        state     <= StFill;
                    end
                end
                StFill: begin
                    // Indices at or beyond LED_COUNT match no pixel and are dropped.
                    if (own_valid) begin
                        for (int k = 0; k < LED_COUNT; k++) begin
                            if (own_idx == IDX_W'(k)) begin
                                shadow[k*COLOR_W +: COLOR_W] <= own_color;
                            end
                        end
                    end
                    if (!own_req) begin
                        src_grant <= '0;
                        state     <= StIdle;
                    end else if (own_commit) begin
                        state <= StWaitDrv;
                    end
                end
                StWaitDrv: begin
                    if (!drv_busy) begin
                        frame_out   <= shadow;
                        drv_start   <= 1'b1;
                        frame_count <= frame_count + 16'd1;
                        if (hold < HOLD_W'(HOLD_FRAMES)) begin
                            hold <= hold + 1'b1;
                        end
                        tmo_cnt   <= '0;
                        seen_busy <= 1'b0;
                        state     <= StSend;
                    end
                end
                StSend: begin
                    if (drv_busy) begin
                        seen_busy <= 1'b1;
                    end else if (seen_busy) begin
                        state <= StArb;
                    end else if (tmo_cnt == TMO_W'(SEND_TIMEOUT - 1)) begin
                        state <= StArb;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                StArb: begin
                    // pick is the lowest set index, so pick != owner means a higher priority.
                    if (!own_req) begin
                        if (|src_req) begin
                            src_grant <= pick;
                            hold      <= '0;
                            state     <= StFill;
                        end else begin
                            src_grant <= '0;
                            state     <= StIdle;
                        end
                    end else if (pick != src_grant && hold >= HOLD_W'(HOLD_FRAMES)) begin
                        src_grant <= pick;
                        hold      <= '0;
                        state     <= StFill;
                    end else begin
                        state <= StFill;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Scoreboard bench for led_frame_arbiter: expected frames are queued at commit and
// compared against frame_out/frame_count whenever drv_start pulses.
module tb_led_frame_arbiter;

    localparam int NUM_SRC   = 3;
    localparam int LED_COUNT = 11;
    localparam int COLOR_W   = 24;
    localparam int FRAME_W   = LED_COUNT * COLOR_W;

    logic                       clock;
    logic                       reset;
    logic [NUM_SRC-1:0]         src_req;
    logic [NUM_SRC-1:0]         src_wr_valid;
    logic [NUM_SRC*4-1:0]       src_wr_idx;
    logic [NUM_SRC*COLOR_W-1:0] src_wr_color;
    logic [NUM_SRC-1:0]         src_commit;
    logic [NUM_SRC-1:0]         src_grant;
    logic                       drv_busy;
    logic                       drv_start;
    logic [FRAME_W-1:0]         frame_out;
    logic [15:0]                frame_count;

    logic man_busy;
    logic auto_busy;
    logic auto_drv;
    assign drv_busy = man_busy | auto_busy;

    led_frame_arbiter #(
        .NUM_SRC    (NUM_SRC),
        .LED_COUNT  (LED_COUNT),
        .COLOR_W    (COLOR_W),
        .HOLD_FRAMES(4)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .src_req     (src_req),
        .src_wr_valid(src_wr_valid),
        .src_wr_idx  (src_wr_idx),
        .src_wr_color(src_wr_color),
        .src_commit  (src_commit),
        .src_grant   (src_grant),
        .drv_busy    (drv_busy),
        .drv_start   (drv_start),
        .frame_out   (frame_out),
        .frame_count (frame_count)
    );

    typedef struct {
        logic [FRAME_W-1:0] frame;
        logic [15:0]        count;
        int                 start_cyc;
    } exp_t;

    exp_t               sb[$];
    logic [COLOR_W-1:0] exp_shadow [LED_COUNT];
    logic [15:0]        exp_count;
    logic [FRAME_W-1:0] last_frame;
    int                 owner;
    int                 cyc;
    int                 last_start_cyc;
    int                 auto_cnt;
    logic               prev_start;
    int                 errors;
    int                 checks;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [FRAME_W-1:0] act,
                            input logic [FRAME_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [FRAME_W-1:0] pack_shadow();
        logic [FRAME_W-1:0] f;
        for (int k = 0; k < LED_COUNT; k++) f[k*COLOR_W +: COLOR_W] = exp_shadow[k];
        return f;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
        src_wr_valid = '0;
        src_commit   = '0;
    endtask

    task automatic set_px(input int src, input int idx, input logic [COLOR_W-1:0] color);
        src_wr_valid[src]                    = 1'b1;
        src_wr_idx[src*4 +: 4]               = idx[3:0];
        src_wr_color[src*COLOR_W +: COLOR_W] = color;
        if (src == owner && idx < LED_COUNT) exp_shadow[idx] = color;
    endtask

    task automatic set_commit(input int src);
        src_commit[src] = 1'b1;
    endtask

    task automatic expect_frame(input int start_cyc);
        exp_count = exp_count + 16'd1;
        sb.push_back('{frame: pack_shadow(), count: exp_count, start_cyc: start_cyc});
    endtask

    task automatic acquire(input int src);
        src_req[src] = 1'b1;
        step();
        check_eq("grant_acquire", src_grant, FRAME_W'(1 << src));
        owner = src;
    endtask

    task automatic wait_start();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            step();
            n++;
        end
        check_eq("start_timeout", sb.size(), 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < LED_COUNT; k++) exp_shadow[k] = '0;
        exp_count  = '0;
        last_frame = '0;
        owner      = -1;
    endtask

    // Driver model and scoreboard consumer, sampled 1 time unit after each clock edge.
    always @(posedge clock) begin
        #1;
        if (drv_start) begin
            check_eq("start_gap", prev_start, 1'b0);
            if (sb.size() == 0) begin
                check_eq("spurious_start", drv_start, 1'b0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check_eq("frame_out", frame_out, e.frame);
                check_eq("frame_count", frame_count, e.count);
                check_eq("grant_onehot", $countones(src_grant) <= 1, 1'b1);
                if (e.start_cyc >= 0) check_eq("start_cycle", cyc, e.start_cyc);
                last_frame = e.frame;
            end
            last_start_cyc = cyc;
            if (auto_drv) auto_cnt = 5;
        end else if (auto_cnt > 0) begin
            auto_cnt--;
        end
        auto_busy  = (auto_cnt > 0);
        prev_start = drv_start;
    end

    initial begin
        errors = 0; checks = 0;
        auto_cnt = 0; auto_busy = 1'b0; prev_start = 1'b0; last_start_cyc = 0;
        reset = 1'b1; src_req = '0; src_wr_valid = '0; src_wr_idx = '0;
        src_wr_color = '0; src_commit = '0; man_busy = 1'b0; auto_drv = 1'b1;
        model_reset();
        repeat (3) step();
        reset = 1'b0;
        step();
        check_eq("rst_grant", src_grant, 0);
        check_eq("rst_start", drv_start, 0);
        check_eq("rst_frame", frame_out, 0);
        check_eq("rst_count", frame_count, 0);

        // Single source fills every pixel and commits with the driver idle.
        acquire(1);
        for (int k = 0; k < LED_COUNT; k++) begin
            set_px(1, k, 24'h0000FF + COLOR_W'(k));
            step();
        end
        set_commit(1); expect_frame(cyc + 2); step();
        wait_start(); repeat (10) step();
        check_eq("t1_keep", src_grant, 3'b010);

        // Non-owner writes, out-of-range indices, collisions, write+commit together.
        for (int k = 0; k < LED_COUNT; k++) begin
            set_px(2, k, 24'hAA0000 | COLOR_W'(k));
            step();
        end
        set_px(1, 11, 24'hDEAD01); step();
        set_px(1, 15, 24'hDEAD02); step();
        set_px(1, 5, 24'h555555); set_px(2, 5, 24'hBADBAD); step();
        set_px(1, 3, 24'h123456); set_commit(1); expect_frame(cyc + 2); step();
        wait_start(); repeat (10) step();

        // Owner drops its request mid-fill: grant released, no frame sent.
        set_px(1, 0, 24'hFFFFFF); step();
        src_req[1] = 1'b0; step();
        check_eq("t5_grant", src_grant, 0);
        repeat (10) step();
        check_eq("t5_frame_kept", frame_out, last_frame);
        check_eq("t5_count", frame_count, exp_count);

        // Commit while the driver is busy: the frame waits and frame_out stays put.
        acquire(0);
        set_px(0, 1, 24'h00FF00); step();
        man_busy = 1'b1; set_commit(0); step();
        for (int i = 0; i < 50; i++) begin
            step();
            if (i % 10 == 0) check_eq("t3_stable", frame_out, last_frame);
        end
        man_busy = 1'b0; expect_frame(cyc + 1); step();
        wait_start(); repeat (10) step();
        src_req[0] = 1'b0; step();
        check_eq("t3_release", src_grant, 0);

        // Higher-priority request waits until the owner has held the strip for 4 frames.
        acquire(2);
        for (int f = 1; f <= 4; f++) begin
            set_px(2, f, 24'h0F0F00 + COLOR_W'(f)); set_commit(2); expect_frame(cyc + 2);
            step();
            if (f == 1) src_req[0] = 1'b1;
            wait_start(); repeat (10) step();
            check_eq("t4_grant", src_grant, (f == 4) ? 3'b001 : 3'b100);
        end
        src_req = '0; step();
        check_eq("t4_release", src_grant, 0);

        // Reset while waiting on the driver.
        acquire(1);
        set_px(1, 2, 24'h010203); step();
        man_busy = 1'b1; set_commit(1); step();
        repeat (3) step();
        reset = 1'b1; src_req = '0; step();
        check_eq("t6_rst_grant", src_grant, 0);
        check_eq("t6_rst_start", drv_start, 0);
        check_eq("t6_rst_frame", frame_out, 0);
        check_eq("t6_rst_count", frame_count, 0);
        reset = 1'b0; man_busy = 1'b0; model_reset();
        repeat (5) step();

        // Driver never raises busy: SEND gives up after the timeout and ARB releases.
        auto_drv = 1'b0;
        acquire(1);
        set_px(1, 10, 24'hABCDEF); set_commit(1); expect_frame(cyc + 2); step();
        wait_start();
        src_req[1] = 1'b0;
        while (cyc < last_start_cyc + 200) step();
        check_eq("t6_send_hold", src_grant, 3'b010);
        while (cyc < last_start_cyc + 270) step();
        check_eq("t6_timeout_release", src_grant, 0);
        check_eq("t6_count", frame_count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
